// File: rtl/lc3b_pkg.sv
// lc3b_pkg: shared encodings and defaults for the LC-3b bus arbiter.
package lc3b_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_OWNED = 1'b1} arb_state_t;
  localparam logic [1:0] REQ_PC = 2'd0;
  localparam logic [1:0] REQ_MDR = 2'd1;
  localparam logic [1:0] REQ_ALU = 2'd2;
  localparam logic [1:0] REQ_MARMUX = 2'd3;
  localparam int ARB_MAX_HOLD = 8;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: round-robin pick of the first unmasked request after last, wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic [3:0] exclude,
  output logic       found,
  output logic [1:0] winner
);
  logic [3:0] cand;
  logic [1:0] idx;
  assign cand = req & ~exclude;
  // scan farthest-first so the nearest candidate after last is written last and wins
  always_comb begin
    found = 1'b0;
    winner = last;
    idx = last;
    for (int k = 3; k >= 0; k--) begin
      idx = last + 2'(k + 1);
      if (cand[idx]) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/lc3b_bus_arbiter.sv
// lc3b_bus_arbiter: round-robin owner arbitration and 4:1 mux for the LC-3b internal bus.
// Optional LC3B_BUS_LOCK_EN adds a lock input that suppresses hold-limit preemption.
module lc3b_bus_arbiter
  import lc3b_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             reset,
`ifdef LC3B_BUS_LOCK_EN
  input  logic             lock,
`endif
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid
);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  arb_state_t state;
  logic [7:0] hold_cnt;
  logic [1:0] last;
  logic       found;
  logic [1:0] winner;
  logic       can_preempt;
`ifdef LC3B_BUS_LOCK_EN
  assign can_preempt = !lock;
`else
  assign can_preempt = 1'b1;
`endif
  // gnt is zero in IDLE, so masking with it only excludes the owner during OWNED
  rr_pick4 u_pick (
    .req(req),
    .last(last),
    .exclude(gnt),
    .found(found),
    .winner(winner)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      gnt <= '0;
      select <= REQ_PC;
      hold_cnt <= '0;
      last <= REQ_MARMUX;
    end else if (state == ARB_IDLE) begin
      if (found) begin
        state <= ARB_OWNED;
        gnt <= 4'b0001 << winner;
        select <= winner;
        last <= winner;
        hold_cnt <= '0;
      end
    end else if (!req[select]) begin
      state <= ARB_IDLE;
      gnt <= '0;
    end else if (hold_cnt == HOLD_LIM && found && can_preempt) begin
      gnt <= 4'b0001 << winner;
      select <= winner;
      last <= winner;
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LIM) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
  assign bus_valid = |gnt;
  assign bus_out = !bus_valid ? '0 :
                   select == 2'd0 ? in0 :
                   select == 2'd1 ? in1 :
                   select == 2'd2 ? in2 : in3;
endmodule

// File: tb/tb_lc3b_bus_arbiter.sv
// tb_lc3b_bus_arbiter: directed and randomized checks against an owner/run-length reference model.
module tb_lc3b_bus_arbiter;
  localparam int WIDTH = 16;
  localparam int MAX_HOLD = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lock = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [WIDTH-1:0] in0 = 16'h3000;
  logic [WIDTH-1:0] in1 = 16'h1111;
  logic [WIDTH-1:0] in2 = 16'h2222;
  logic [WIDTH-1:0] in3 = 16'h3333;
  logic [3:0] gnt;
  logic [1:0] select;
  logic [WIDTH-1:0] bus_out;
  logic bus_valid;
  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;
  // reference model: who owns the bus, for how many cycles, and where the search resumes
  int m_owner = -1;
  int m_cycles = 0;
  int m_last = 3;
  int m_sel = 0;
  int m_w;
  logic [3:0] prev_req = 4'b0000;

  lc3b_bus_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .reset(reset),
`ifdef LC3B_BUS_LOCK_EN
    .lock(lock),
`endif
    .req(req),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .gnt(gnt),
    .select(select),
    .bus_out(bus_out),
    .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int from, input int excl);
    int i;
    for (int o = 1; o <= 4; o++) begin
      i = (from + o) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] data_of(input int s);
    return s == 0 ? in0 : s == 1 ? in1 : s == 2 ? in2 : in3;
  endfunction

  always @(posedge clk) begin
    prev_req = req;
    m_w = -1;
    if (reset) begin
      m_owner = -1;
      m_last = 3;
      m_sel = 0;
    end else if (m_owner < 0) begin
      m_w = pick(req, m_last, -1);
      if (m_w >= 0) begin
        m_owner = m_w;
        m_last = m_w;
        m_sel = m_w;
        m_cycles = 1;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else begin
      if (m_cycles >= MAX_HOLD && !lock) m_w = pick(req, m_last, m_owner);
      if (m_w >= 0) begin
        m_owner = m_w;
        m_last = m_w;
        m_sel = m_w;
        m_cycles = 1;
      end else begin
        m_cycles++;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("gnt", 32'(gnt), m_owner < 0 ? 32'd0 : 32'd1 << m_owner);
      chk("select", 32'(select), 32'(m_sel));
      chk("bus_valid", 32'(bus_valid), m_owner < 0 ? 32'd0 : 32'd1);
      chk("bus_out", 32'(bus_out), m_owner < 0 ? 32'd0 : 32'(data_of(m_owner)));
      chk("gnt_without_req", 32'(gnt & ~prev_req), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    checking = 1'b1;
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus", 32'(bus_out), 32'd0);
    reset = 1'b0;
    req = 4'b0001;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_select", 32'(select), 32'd0);
    chk("first_valid", 32'(bus_valid), 32'd1);
    chk("first_bus", 32'(bus_out), 32'h3000);
    req = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int t = 1; t <= 33; t++) begin
      tick();
      chk("rr_order", 32'(gnt), 32'd1 << (((t - 1) / MAX_HOLD) % 4));
    end
    req = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0100;
    tick();
    chk("own2_gnt", 32'(gnt), 32'h4);
    req = 4'b0110;
    tick();
    tick();
    chk("own2_hold", 32'(gnt), 32'h4);
    req = 4'b0010;
    tick();
    chk("drop_bubble", 32'(gnt), 32'd0);
    tick();
    chk("drop_next", 32'(gnt), 32'h2);
    req = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sole_hold", 32'(gnt), 32'h8);
    end
    req = 4'b1001;
    tick();
    chk("sole_handover", 32'(gnt), 32'h1);
    reset = 1'b1;
    req = 4'b0110;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_select", 32'(select), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    chk("post_rst_select", 32'(select), 32'd1);
`ifdef LC3B_BUS_LOCK_EN
    req = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0001;
    tick();
    lock = 1'b1;
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("lock_hold", 32'(gnt), 32'h1);
    end
    lock = 1'b0;
    tick();
    chk("lock_release", 32'(gnt), 32'h2);
`endif
    req = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 199) == 0;
      for (int i = 0; i < 4; i++) begin
        if (i == m_owner) req[i] = $urandom_range(0, 9) != 0;
        else if (!req[i]) req[i] = $urandom_range(0, 3) == 0;
      end
`ifdef LC3B_BUS_LOCK_EN
      lock = $urandom_range(0, 3) == 0;
`endif
      in0 = 16'($urandom);
      in1 = 16'($urandom);
      in2 = 16'($urandom);
      in3 = 16'($urandom);
      tick();
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
